// File: rtl/cdda_capture_if.sv
// CPU-side SRAM-style bus of the CDDA capture block: address, data, strobes and stall.
interface cdda_capture_if;
  logic [10:0] sram_a;
  logic [7:0]  sram_d_in;
  logic [7:0]  sram_d_out;
  logic        sram_cs;
  logic        sram_oe;
  logic        sram_we;
  logic        sram_wait;

  modport master (
    output sram_a, sram_d_in, sram_cs, sram_oe, sram_we,
    input  sram_d_out, sram_wait
  );

  modport slave (
    input  sram_a, sram_d_in, sram_cs, sram_oe, sram_we,
    output sram_d_out, sram_wait
  );
endinterface

// File: rtl/cdda_capture.sv
// Captures serial CDDA frames (16-bit left/right words) into a 256-frame buffer readable over the CPU bus.
// Register reads are combinational; buffer reads stall the CPU (sram_wait) for one clk, then hold data.
module cdda_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bck_in,
  input  logic            sd_in,
  input  logic            lrck_in,
  cdda_capture_if.slave   bus
);

  logic [SYNC_STAGES-1:0] bck_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic                   bck_prev;
  logic                   run_ok;
  logic                   bck_s;
  logic                   sd_s;
  logic                   lrck_s;
  logic                   bck_rise;

  logic                   enabled;
  logic                   overflow;
  logic                   pend_left;
  logic                   lr_prev;
  logic [7:0]             bufpos;
  logic [7:0]             last_valid;
  logic [7:0]             scratch;
  logic [15:0]            shreg;
  logic [15:0]            left_word;

  logic                   cap;
  logic                   word_done;
  logic                   frame_done;
  logic                   ovf_set;
  logic                   frame_wr;
  logic                   reg_wr;
  logic [1:0]             reg_sel;

  logic                   buf_rd;
  logic                   rd_phase;
  logic [7:0]             frame_idx;
  logic [15:0]            ram_l [256];
  logic [15:0]            ram_r [256];
  logic [15:0]            rd_l;
  logic [15:0]            rd_r;
  logic                   rd_ch;
  logic                   rd_hi;
  logic [15:0]            rd_word;
  logic [7:0]             buf_byte;
  logic [7:0]             reg_dat;

  assign bck_s  = bck_sync[SYNC_STAGES-1];
  assign sd_s   = sd_sync[SYNC_STAGES-1];
  assign lrck_s = lrck_sync[SYNC_STAGES-1];

  // run_ok masks the first clk after reset release so a stale bck level is not seen as an edge
  assign bck_rise = bck_s & ~bck_prev & run_ok;

  assign cap        = enabled & bck_rise;
  assign word_done  = cap & (lrck_s != lr_prev);
  assign frame_done = word_done & lr_prev & pend_left;
  assign ovf_set    = frame_done & (bufpos == last_valid);
  assign frame_wr   = frame_done & ~ovf_set;

  assign reg_wr    = bus.sram_cs & bus.sram_we & ~bus.sram_a[10];
  assign reg_sel   = bus.sram_a[3:2];
  assign buf_rd    = bus.sram_cs & bus.sram_oe & bus.sram_a[10];
  assign frame_idx = bus.sram_a[9:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bck_sync  <= '0;
      sd_sync   <= '0;
      lrck_sync <= '0;
      bck_prev  <= 1'b0;
      run_ok    <= 1'b0;
    end else begin
      bck_sync  <= {bck_sync[SYNC_STAGES-2:0], bck_in};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sd_in};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck_in};
      bck_prev  <= bck_s;
      run_ok    <= 1'b1;
    end
  end

  // Capture datapath: while disabled, lr_prev tracks lrck so enabling starts aligned to the current channel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      left_word <= '0;
      pend_left <= 1'b0;
      lr_prev   <= 1'b0;
    end else if (!enabled) begin
      shreg     <= '0;
      pend_left <= 1'b0;
      lr_prev   <= lrck_s;
    end else if (cap) begin
      shreg   <= {shreg[14:0], sd_s};
      lr_prev <= lrck_s;
      if (word_done) begin
        if (!lr_prev) begin
          left_word <= shreg;
          pend_left <= 1'b1;
        end else begin
          pend_left <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enabled    <= 1'b0;
      overflow   <= 1'b0;
      bufpos     <= 8'h00;
      last_valid <= 8'h00;
      scratch    <= 8'h55;
      rd_phase   <= 1'b0;
    end else begin
      rd_phase <= buf_rd;
      if (reg_wr && reg_sel == 2'd0) begin
        enabled <= bus.sram_d_in[0];
      end
      // A frame overflow in the same clk as a CPU clear keeps the flag set
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (reg_wr && reg_sel == 2'd0 && bus.sram_d_in[1]) begin
        overflow <= 1'b0;
      end
      if (reg_wr && reg_sel == 2'd1) begin
        bufpos <= bus.sram_d_in;
      end else if (frame_wr) begin
        bufpos <= bufpos + 8'd1;
      end
      if (reg_wr && reg_sel == 2'd2) begin
        last_valid <= bus.sram_d_in;
      end
      if (reg_wr && reg_sel == 2'd3) begin
        scratch <= bus.sram_d_in;
      end
    end
  end

  // Buffer RAMs: no reset, one synchronous read port each for the CPU
  always_ff @(posedge clk) begin
    if (frame_wr) begin
      ram_l[bufpos] <= left_word;
      ram_r[bufpos] <= shreg;
    end
    if (buf_rd) begin
      rd_l  <= ram_l[frame_idx];
      rd_r  <= ram_r[frame_idx];
      rd_ch <= bus.sram_a[1];
      rd_hi <= bus.sram_a[0];
    end
  end

  assign rd_word  = rd_ch ? rd_r : rd_l;
  assign buf_byte = rd_hi ? rd_word[15:8] : rd_word[7:0];

  always_comb begin
    reg_dat = 8'h00;
    case (reg_sel)
      2'd0:    reg_dat = {6'b0, overflow, enabled};
      2'd1:    reg_dat = bufpos;
      2'd2:    reg_dat = last_valid;
      default: reg_dat = scratch;
    endcase
  end

  assign bus.sram_d_out = bus.sram_a[10] ? buf_byte : reg_dat;
  assign bus.sram_wait  = rst & buf_rd & ~rd_phase;

endmodule
